// File: rtl/sumsq_pkg.sv
// Shared types and sizing for the serial sum-of-squares unit.
// Holds the FSM state encoding, the default operand width and derived widths.
package sumsq_pkg;

    localparam int SUMSQ_W = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int SUMSQ_RW = 2 * SUMSQ_W + 1;
    localparam int SUMSQ_CW = cnt_width(SUMSQ_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_X = 2'd1,
        SQ_Y = 2'd2,
        DONE = 2'd3
    } sumsq_state_t;

endpackage

// File: rtl/sumsq_serial_if.sv
// Operand/result handshake bundle between a producer and the sum-of-squares unit.
// master = producer/consumer side, slave = the computing block.
interface sumsq_serial_if import sumsq_pkg::*; #(
    parameter int W = SUMSQ_W
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           out_valid;
    logic           out_ready;
    logic [2*W:0]   out_sum;
    logic           busy;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/sumsq_serial_sq_step.sv
// One shift-add step: acc_next = acc + (op[cnt] ? op << cnt : 0).
// Purely combinational; no backpressure.
module sq_step import sumsq_pkg::*; #(
    parameter int W  = SUMSQ_W,
    parameter int RW = SUMSQ_RW,
    parameter int CW = SUMSQ_CW
) (
    input  logic [RW-1:0] i_acc,
    input  logic [W-1:0]  i_op,
    input  logic [CW-1:0] i_cnt,
    output logic [RW-1:0] o_acc_next
);
    logic          w_bit;
    logic [RW-1:0] w_addend;

    assign w_bit      = i_op[i_cnt];
    assign w_addend   = w_bit ? (RW'(i_op) << i_cnt) : '0;
    assign o_acc_next = i_acc + w_addend;
endmodule

// File: rtl/sumsq_serial.sv
// Serial X*X + Y*Y via one conditional add per cycle; SUMSQ_SAT_EN clamps to 2W bits.
// Latency: out_valid rises 2*W edges after accept; one result per 2*W+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module sumsq_serial import sumsq_pkg::*; #(
    parameter int W = SUMSQ_W
) (
    input  logic           clk,
    input  logic           rst_n,
    sumsq_serial_if.slave  bus
);
    localparam int RW = 2 * W + 1;
    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    sumsq_state_t  r_state;
    sumsq_state_t  w_state_next;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;
    logic [W-1:0]  w_op;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_last;
    logic [RW-1:0] r_acc;
    logic [RW-1:0] w_acc_next;
    logic [RW-1:0] w_sum_fmt;
    logic [RW-1:0] r_out_sum;
    logic          r_out_valid;
    logic          w_in_ready;
    logic          w_busy;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_op       = (r_state == SQ_Y) ? r_y : r_x;

    sq_step #(
        .W  (W),
        .RW (RW),
        .CW (CW)
    ) u_sq_step (
        .i_acc      (r_acc),
        .i_op       (w_op),
        .i_cnt      (r_cnt),
        .o_acc_next (w_acc_next)
    );

`ifdef SUMSQ_SAT_EN
    // Any sum reaching bit 2W saturates so a 2W-bit consumer never wraps.
    assign w_sum_fmt = w_acc_next[RW-1] ? {1'b0, {(RW-1){1'b1}}} : w_acc_next;
`else
    assign w_sum_fmt = w_acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SQ_X;
            SQ_X:    if (w_cnt_last)    w_state_next = SQ_Y;
            SQ_Y:    if (w_cnt_last)    w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == IDLE);
        w_busy     = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x   <= bus.in_x;
                        r_y   <= bus.in_y;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                SQ_X: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
                end
                SQ_Y: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
                    if (w_cnt_last) begin
                        r_out_sum   <= w_sum_fmt;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
endmodule

// File: tb/tb_sumsq_serial.sv
// Bench for sumsq_serial: vector table, stall/reset corner sequences and a
// randomized back-to-back run scored against an arithmetic reference queue.
module tb_sumsq_serial;
    import sumsq_pkg::*;

    localparam int W  = 8;
    localparam int RW = 2 * W + 1;
    localparam int LAT = 2 * W;
    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sumsq_serial_if #(.W(W)) bus();

    sumsq_serial #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [RW-1:0] exp;
    } vec_t;

    vec_t          tbl[10];
    logic [RW-1:0] sb_q[$];

    function automatic logic [RW-1:0] ref_sumsq(input int unsigned x, input int unsigned y);
        int unsigned s;
        s = x * x + y * y;
`ifdef SUMSQ_SAT_EN
        if (s >= (32'd1 << (2 * W))) s = (32'd1 << (2 * W)) - 1;
`endif
        return RW'(s);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; counts edges until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic txn(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [RW-1:0] sum, output int lat);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        tick();
        bus.in_valid = 1'b0;
        bus.in_x     = W'($urandom);
        bus.in_y     = W'($urandom);
        wait_valid(lat);
        sum = bus.out_sum;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] sum;
        int            lat;
        int            seen;
        int            sent;
        int            recv;
        int            cyc;
        logic          acc_now;
        logic [RW-1:0] exp_v;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;

        tbl[0] = '{x: 8'd3,   y: 8'd4,   exp: 17'd25};
        tbl[1] = '{x: 8'd0,   y: 8'd0,   exp: 17'd0};
        tbl[2] = '{x: 8'd255, y: 8'd0,   exp: 17'd65025};
        tbl[3] = '{x: 8'd0,   y: 8'd255, exp: 17'd65025};
        tbl[4] = '{x: 8'd1,   y: 8'd0,   exp: 17'd1};
        tbl[5] = '{x: 8'd128, y: 8'd128, exp: 17'd32768};
        tbl[6] = '{x: 8'd181, y: 8'd181, exp: 17'd65522};
`ifdef SUMSQ_SAT_EN
        tbl[7] = '{x: 8'd255, y: 8'd255, exp: 17'd65535};
        tbl[8] = '{x: 8'd182, y: 8'd181, exp: 17'd65535};
`else
        tbl[7] = '{x: 8'd255, y: 8'd255, exp: 17'd130050};
        tbl[8] = '{x: 8'd182, y: 8'd181, exp: 17'd65885};
`endif
        tbl[9] = '{x: 8'd170, y: 8'd85,  exp: 17'd36125};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum",   64'(bus.out_sum),   64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        rst_n = 1'b1;
        tick();

        // Vector table, out_ready held high
        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].x, tbl[i].y, sum, lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(LAT));
            chk($sformatf("tbl%0d_sum", i), 64'(sum), 64'(tbl[i].exp));
            tick();
            chk($sformatf("tbl%0d_idle", i), 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        end

        // Output stall: result held, new in_valid ignored, next accept one cycle after handshake
        bus.out_ready = 1'b0;
        txn(8'd12, 8'd5, sum, lat);
        chk("stall_lat", 64'(lat), 64'(LAT));
        chk("stall_sum", 64'(sum), 64'd169);
        bus.in_valid = 1'b1;
        bus.in_x     = 8'd9;
        bus.in_y     = 8'd9;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_sum", k),   64'(bus.out_sum),   64'd169);
            chk($sformatf("stall%0d_valid", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stall%0d_rdy", k),   64'(bus.in_ready),  64'd0);
            chk($sformatf("stall%0d_busy", k),  64'(bus.busy),      64'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("hs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("hs_in_ready",  64'(bus.in_ready),  64'd1);
        chk("hs_sum_kept",  64'(bus.out_sum),   64'd169);
        chk("hs_busy",      64'(bus.busy),      64'd0);
        tick();
        chk("next_acc_rdy",  64'(bus.in_ready), 64'd0);
        chk("next_acc_busy", 64'(bus.busy),     64'd1);
        bus.in_valid = 1'b0;
        bus.in_x     = 8'd255;
        bus.in_y     = 8'd255;
        wait_valid(lat);
        chk("next_lat", 64'(lat), 64'(LAT));
        chk("next_sum", 64'(bus.out_sum), 64'(ref_sumsq(9, 9)));
        tick();

        // Reset in the middle of a computation
        bus.in_valid = 1'b1;
        bus.in_x     = 8'd200;
        bus.in_y     = 8'd100;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_busy",      64'(bus.busy),      64'd0);
        chk("mrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("mrst_out_sum",   64'(bus.out_sum),   64'd0);
        seen = 0;
        repeat (7) begin
            tick();
            if (bus.out_valid || bus.busy) seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            if (bus.out_valid || bus.busy) seen++;
        end
        chk("mrst_quiet", 64'(seen), 64'd0);
        txn(8'd1, 8'd1, sum, lat);
        chk("post_rst_lat", 64'(lat), 64'(LAT));
        chk("post_rst_sum", 64'(sum), 64'd2);
        tick();

        // Randomized back-to-back stream with random output backpressure
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < N_RAND && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            acc_now = bus.in_valid && bus.in_ready;
            if (acc_now) begin
                sb_q.push_back(ref_sumsq(int'(bus.in_x), int'(bus.in_y)));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_extra", 64'(bus.out_sum), 64'({(RW+1){1'b1}}));
                end else begin
                    exp_v = sb_q.pop_front();
                    chk($sformatf("rnd%0d_sum", recv), 64'(bus.out_sum), 64'(exp_v));
                end
                recv++;
            end
            @(posedge clk);
            #1;
            if (acc_now || !bus.in_valid) begin
                if (sent < N_RAND) begin
                    bus.in_valid = 1'b1;
                    bus.in_x = ($urandom_range(0, 7) == 0) ? 8'd255 : W'($urandom_range(0, 255));
                    bus.in_y = ($urandom_range(0, 7) == 0) ? 8'd255 : W'($urandom_range(0, 255));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        chk("rnd_recv_count", 64'(recv), 64'(N_RAND));
        chk("rnd_sent_count", 64'(sent), 64'(N_RAND));
        chk("rnd_queue_left", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
